lpc_cycle_decoder: RTL and testbench

LPC_CYCLE_DECODER -- requirements
Module: lpc_cycle_decoder

---
 rtl/lpc_cycle_decoder.sv | 196 +++++++++++++++++++
 tb/tb_lpc_cycle_decoder.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_cycle_decoder.sv
// LPC target-side cycle decoder: follows LFRAME#/LAD[3:0] and presents each
// completed I/O, memory or DMA cycle as one out_valid pulse with its fields.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for LFRAME# low with a 0000 START nibble
// CYCTYPE | START seen; next nibble is CYCTYPE+DIR
// ADDR    | shifting in 4 (I/O) or 8 (memory) address nibbles, MSB first
// CHAN    | DMA channel number and terminal-count bit
// SIZE    | DMA transfer size
// HDATA   | host drives data bytes, low nibble first
// TAR1    | two-clock turnaround to the peripheral
// SYNC    | peripheral drives wait / ready / error codes
// PDATA   | peripheral drives one data byte, low nibble first
// TAR2    | two-clock turnaround back to the host
module lpc_cycle_decoder #(
  parameter bit          ENABLE_MEM   = 1'b1,
  parameter bit          ENABLE_DMA   = 1'b1,
  parameter int unsigned SYNC_TIMEOUT = 1023
) (
  input  logic        lpc_clock,
  input  logic        reset,
  input  logic        lpc_reset,
  input  logic        lpc_frame,
  input  logic [3:0]  lpc_ad,
  output logic        out_valid,
  output logic [3:0]  out_cyctype_dir,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic [1:0]  out_size,
  output logic [2:0]  out_dma_channel,
  output logic        out_dma_tc,
  output logic        out_error,
  output logic        out_abort,
  output logic        out_timeout
);

  typedef enum logic [3:0] {
    S_IDLE, S_CYCTYPE, S_ADDR, S_CHAN, S_SIZE,
    S_HDATA, S_TAR1, S_SYNC, S_PDATA, S_TAR2
  } state_t;

  state_t      state, state_next;
  logic [2:0]  nib_left;
  logic [1:0]  byte_idx;
  logic        hi_nib;
  logic        tar_cnt;
  logic [15:0] wait_cnt;

  logic        complete, timeout_hit, abort_hit, accept, run;
  logic        is_dma, dir, host_data, is_wait;

  // For DMA the DIR bit names the memory side, so host data flows on DMA reads.
  assign is_dma    = (out_cyctype_dir[3:2] == 2'b10);
  assign dir       = out_cyctype_dir[1];
  assign host_data = is_dma ? ~dir : dir;
  assign is_wait   = (lpc_ad == 4'b0101) || (lpc_ad == 4'b0110);
  assign run       = lpc_frame | complete;

  // State register.
  always_ff @(posedge lpc_clock) begin
    if (reset || !lpc_reset) state <= S_IDLE;
    else                     state <= state_next;
  end

  // Next-state decode; a START overrides everything except a completing nibble.
  always_comb begin
    state_next  = state;
    complete    = 1'b0;
    timeout_hit = 1'b0;
    abort_hit   = 1'b0;
    accept      = 1'b0;
    case (state)
      S_IDLE: state_next = S_IDLE;
      S_CYCTYPE: begin
        case (lpc_ad[3:2])
          2'b00:   state_next = S_ADDR;
          2'b01:   state_next = ENABLE_MEM ? S_ADDR : S_IDLE;
          2'b10:   state_next = ENABLE_DMA ? S_CHAN : S_IDLE;
          default: state_next = S_IDLE;
        endcase
        accept = (state_next != S_IDLE);
      end
      S_ADDR:  if (nib_left == 3'd0) state_next = dir ? S_HDATA : S_TAR1;
      S_CHAN:  state_next = S_SIZE;
      S_SIZE: begin
        if (lpc_ad[1:0] == 2'b10) state_next = S_IDLE;
        else                      state_next = dir ? S_TAR1 : S_HDATA;
      end
      S_HDATA: if (hi_nib && byte_idx == out_size) state_next = S_TAR1;
      S_TAR1:  if (tar_cnt) state_next = S_SYNC;
      S_SYNC: begin
        if (is_wait) begin
          if (wait_cnt == 16'd0) begin
            state_next  = S_IDLE;
            timeout_hit = 1'b1;
          end
        end else if (lpc_ad == 4'b0000 || lpc_ad == 4'b1010 ||
                     (lpc_ad == 4'b1001 && is_dma)) begin
          if (host_data) begin
            complete   = 1'b1;
            state_next = S_TAR2;
          end else begin
            state_next = S_PDATA;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_PDATA: begin
        if (hi_nib) begin
          if (byte_idx == out_size) begin
            complete   = 1'b1;
            state_next = S_TAR2;
          end else begin
            state_next = S_SYNC;
          end
        end
      end
      S_TAR2:  if (tar_cnt) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (!lpc_frame) begin
      state_next  = (lpc_ad == 4'b0000) ? S_CYCTYPE : S_IDLE;
      timeout_hit = 1'b0;
      accept      = 1'b0;
      abort_hit   = !complete && state != S_IDLE && state != S_CYCTYPE;
    end
  end

  // Datapath: field capture, nibble/byte counters, wait down-counter, pulses.
  always_ff @(posedge lpc_clock) begin
    if (reset || !lpc_reset) begin
      out_valid       <= 1'b0;
      out_cyctype_dir <= 4'd0;
      out_addr        <= 32'd0;
      out_data        <= 32'd0;
      out_size        <= 2'd0;
      out_dma_channel <= 3'd0;
      out_dma_tc      <= 1'b0;
      out_error       <= 1'b0;
      out_abort       <= 1'b0;
      out_timeout     <= 1'b0;
      nib_left        <= 3'd0;
      byte_idx        <= 2'd0;
      hi_nib          <= 1'b0;
      tar_cnt         <= 1'b0;
      wait_cnt        <= 16'd0;
    end else begin
      out_valid   <= complete;
      out_abort   <= abort_hit;
      out_timeout <= timeout_hit;
      hi_nib      <= 1'b0;
      tar_cnt     <= 1'b0;
      if (state_next == S_SYNC && state != S_SYNC)
        wait_cnt <= 16'(SYNC_TIMEOUT);
      else if (state == S_SYNC && is_wait)
        wait_cnt <= wait_cnt - 16'd1;
      if (run) begin
        case (state)
          S_CYCTYPE: begin
            if (accept) begin
              out_cyctype_dir <= lpc_ad;
              out_addr        <= 32'd0;
              out_data        <= 32'd0;
              out_error       <= 1'b0;
              out_size        <= 2'd0;
              out_dma_channel <= 3'd0;
              out_dma_tc      <= 1'b0;
              byte_idx        <= 2'd0;
              nib_left        <= lpc_ad[2] ? 3'd7 : 3'd3;
            end
          end
          S_ADDR: begin
            out_addr <= {out_addr[27:0], lpc_ad};
            nib_left <= nib_left - 3'd1;
          end
          S_CHAN: begin
            out_dma_channel <= lpc_ad[2:0];
            out_dma_tc      <= lpc_ad[3];
          end
          S_SIZE: if (lpc_ad[1:0] != 2'b10) out_size <= lpc_ad[1:0];
          S_HDATA, S_PDATA: begin
            out_data[{byte_idx, hi_nib, 2'b00} +: 4] <= lpc_ad;
            hi_nib <= ~hi_nib;
            if (hi_nib) byte_idx <= byte_idx + 2'd1;
          end
          S_TAR1, S_TAR2: tar_cnt <= ~tar_cnt;
          S_SYNC: if (lpc_ad == 4'b1010) out_error <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// Directed bench for lpc_cycle_decoder: one task per scenario, nibble-level stimulus.
module tb_lpc_cycle_decoder;

  logic        lpc_clock = 1'b0;
  logic        reset = 1'b1;
  logic        lpc_reset = 1'b1;
  logic        lpc_frame = 1'b1;
  logic [3:0]  lpc_ad = 4'hF;

  logic        out_valid, out_dma_tc, out_error, out_abort, out_timeout;
  logic [3:0]  out_cyctype_dir;
  logic [31:0] out_addr, out_data;
  logic [1:0]  out_size;
  logic [2:0]  out_dma_channel;

  logic        m_valid, m_tc, m_error, m_abort, m_timeout;
  logic [3:0]  m_cyc;
  logic [31:0] m_addr, m_data;
  logic [1:0]  m_size;
  logic [2:0]  m_ch;

  logic [77:0] all_out, m_all;
  assign all_out = {out_valid, out_cyctype_dir, out_addr, out_data, out_size,
                    out_dma_channel, out_dma_tc, out_error, out_abort, out_timeout};
  assign m_all   = {m_valid, m_cyc, m_addr, m_data, m_size, m_ch, m_tc,
                    m_error, m_abort, m_timeout};

  int checks = 0;
  int errors = 0;
  int vcnt = 0, acnt = 0, tcnt = 0, v2cnt = 0;

  lpc_cycle_decoder #(.ENABLE_MEM(1'b1), .ENABLE_DMA(1'b1), .SYNC_TIMEOUT(4)) dut (
    .lpc_clock(lpc_clock), .reset(reset), .lpc_reset(lpc_reset),
    .lpc_frame(lpc_frame), .lpc_ad(lpc_ad),
    .out_valid(out_valid), .out_cyctype_dir(out_cyctype_dir),
    .out_addr(out_addr), .out_data(out_data), .out_size(out_size),
    .out_dma_channel(out_dma_channel), .out_dma_tc(out_dma_tc),
    .out_error(out_error), .out_abort(out_abort), .out_timeout(out_timeout)
  );

  lpc_cycle_decoder #(.ENABLE_MEM(1'b0), .ENABLE_DMA(1'b0)) dut_min (
    .lpc_clock(lpc_clock), .reset(reset), .lpc_reset(lpc_reset),
    .lpc_frame(lpc_frame), .lpc_ad(lpc_ad),
    .out_valid(m_valid), .out_cyctype_dir(m_cyc),
    .out_addr(m_addr), .out_data(m_data), .out_size(m_size),
    .out_dma_channel(m_ch), .out_dma_tc(m_tc),
    .out_error(m_error), .out_abort(m_abort), .out_timeout(m_timeout)
  );

  always #5 lpc_clock = ~lpc_clock;

  // Drive one nibble, let the DUT sample it, then tally the output pulses.
  task automatic step(input logic f, input logic [3:0] a);
    @(negedge lpc_clock);
    lpc_frame = f;
    lpc_ad    = a;
    @(posedge lpc_clock);
    #1;
    if (out_valid)   vcnt++;
    if (out_abort)   acnt++;
    if (out_timeout) tcnt++;
    if (m_valid)     v2cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1'b1, 4'hF);
    step(1'b1, 4'hF);
    checks++;
    if (all_out !== 78'd0) begin
      errors++; $display("FAIL reset_outputs got %h expected 0", all_out);
    end
    checks++;
    if (m_all !== 78'd0) begin
      errors++; $display("FAIL reset_outputs_min got %h expected 0", m_all);
    end
    reset = 1'b0;
    step(1'b1, 4'hF);
    checks++;
    if (all_out !== 78'd0) begin
      errors++; $display("FAIL idle_after_reset got %h expected 0", all_out);
    end
  endtask

  task automatic test_io_write();
    int v0 = vcnt;
    int w0 = v2cnt;
    step(1'b0, 4'h0); step(1'b1, 4'h2);
    step(1'b1, 4'h0); step(1'b1, 4'h0); step(1'b1, 4'h8); step(1'b1, 4'h0);
    step(1'b1, 4'h5); step(1'b1, 4'hA);
    step(1'b1, 4'hF); step(1'b1, 4'hF);
    checks++;
    if (vcnt != v0) begin
      errors++; $display("FAIL io_write_early_valid got %0d expected 0", vcnt - v0);
    end
    step(1'b1, 4'h0);
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 32'h0000_0080 || out_data !== 32'h0000_00A5 ||
        out_size !== 2'd0 || out_cyctype_dir !== 4'h2 || out_error !== 1'b0) begin
      errors++;
      $display("FAIL io_write_fields got v=%b a=%h d=%h s=%0d c=%h e=%b expected v=1 a=00000080 d=000000a5 s=0 c=2 e=0",
               out_valid, out_addr, out_data, out_size, out_cyctype_dir, out_error);
    end
    step(1'b1, 4'hF);
    checks++;
    if (out_valid !== 1'b0 || out_addr !== 32'h0000_0080 || out_data !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL io_write_hold got v=%b a=%h d=%h expected v=0 a=00000080 d=000000a5",
               out_valid, out_addr, out_data);
    end
    step(1'b1, 4'hF);
    checks++;
    if (v2cnt - w0 != 1) begin
      errors++; $display("FAIL io_write_min_valid got %0d expected 1", v2cnt - w0);
    end
  endtask

  task automatic test_unsupported();
    int v0 = vcnt;
    step(1'b0, 4'h0); step(1'b1, 4'hC);
    checks++;
    if (out_cyctype_dir !== 4'h2) begin
      errors++; $display("FAIL unsupported_cyctype got %h expected 2", out_cyctype_dir);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 4'h0);
    step(1'b1, 4'h0); step(1'b1, 4'h1); step(1'b1, 4'h2);
    checks++;
    if (vcnt != v0) begin
      errors++; $display("FAIL unsupported_valid got %0d expected 0", vcnt - v0);
    end
  endtask

  task automatic test_mem_read();
    int v0 = vcnt;
    int w0 = v2cnt;
    step(1'b0, 4'h0); step(1'b1, 4'h4);
    checks++;
    if (out_data !== 32'd0 || out_cyctype_dir !== 4'h4) begin
      errors++; $display("FAIL mem_accept_clear got d=%h c=%h expected d=0 c=4", out_data, out_cyctype_dir);
    end
    for (int i = 0; i < 7; i++) step(1'b1, 4'hF);
    step(1'b1, 4'h0);
    step(1'b1, 4'hF); step(1'b1, 4'hF);
    step(1'b1, 4'h6); step(1'b1, 4'h6); step(1'b1, 4'h6); step(1'b1, 4'h0);
    step(1'b1, 4'h3);
    checks++;
    if (vcnt != v0) begin
      errors++; $display("FAIL mem_early_valid got %0d expected 0", vcnt - v0);
    end
    step(1'b1, 4'hC);
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 32'hFFFF_FFF0 || out_data !== 32'h0000_00C3 ||
        out_error !== 1'b0 || out_size !== 2'd0) begin
      errors++;
      $display("FAIL mem_read_fields got v=%b a=%h d=%h e=%b s=%0d expected v=1 a=fffffff0 d=000000c3 e=0 s=0",
               out_valid, out_addr, out_data, out_error, out_size);
    end
    step(1'b1, 4'hF); step(1'b1, 4'hF);
    checks++;
    if (v2cnt != w0) begin
      errors++; $display("FAIL mem_disabled_valid got %0d expected 0", v2cnt - w0);
    end
  endtask

  task automatic test_wait_boundary();
    int t0 = tcnt;
    step(1'b0, 4'h0); step(1'b1, 4'h0);
    step(1'b1, 4'h1); step(1'b1, 4'h2); step(1'b1, 4'h3); step(1'b1, 4'h4);
    step(1'b1, 4'hF); step(1'b1, 4'hF);
    for (int i = 0; i < 4; i++) step(1'b1, 4'h5);
    step(1'b1, 4'h0);
    step(1'b1, 4'h7); step(1'b1, 4'hE);
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 32'h0000_1234 || out_data !== 32'h0000_00E7 ||
        tcnt != t0) begin
      errors++;
      $display("FAIL wait_boundary got v=%b a=%h d=%h to=%0d expected v=1 a=00001234 d=000000e7 to=0",
               out_valid, out_addr, out_data, tcnt - t0);
    end
    step(1'b1, 4'hF); step(1'b1, 4'hF);
  endtask

  task automatic test_timeout();
    int t0 = tcnt;
    int v0 = vcnt;
    step(1'b0, 4'h0); step(1'b1, 4'h0);
    step(1'b1, 4'h0); step(1'b1, 4'h0); step(1'b1, 4'h0); step(1'b1, 4'h1);
    step(1'b1, 4'hF); step(1'b1, 4'hF);
    for (int i = 0; i < 4; i++) step(1'b1, 4'h5);
    checks++;
    if (out_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_early got %b expected 0", out_timeout);
    end
    step(1'b1, 4'h5);
    checks++;
    if (out_timeout !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL timeout_pulse got to=%b v=%b expected to=1 v=0", out_timeout, out_valid);
    end
    step(1'b1, 4'h0);
    checks++;
    if (out_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_width got %b expected 0", out_timeout);
    end
    step(1'b1, 4'h1); step(1'b1, 4'h2);
    checks++;
    if (vcnt != v0 || tcnt - t0 != 1) begin
      errors++; $display("FAIL timeout_idle got v=%0d to=%0d expected v=0 to=1", vcnt - v0, tcnt - t0);
    end
  endtask

  task automatic test_dma_write();
    int v0 = vcnt;
    int w0 = v2cnt;
    step(1'b0, 4'h0); step(1'b1, 4'hA); step(1'b1, 4'hA); step(1'b1, 4'h3);
    step(1'b1, 4'hF); step(1'b1, 4'hF);
    for (int b = 0; b < 4; b++) begin
      step(1'b1, 4'h9);
      step(1'b1, 4'(2 * b + 1));
      if (b < 3) step(1'b1, 4'(2 * b + 2));
    end
    checks++;
    if (vcnt != v0) begin
      errors++; $display("FAIL dma_early_valid got %0d expected 0", vcnt - v0);
    end
    step(1'b1, 4'h8);
    checks++;
    if (out_valid !== 1'b1 || out_dma_channel !== 3'd2 || out_dma_tc !== 1'b1 ||
        out_size !== 2'd3 || out_data !== 32'h8765_4321 || out_addr !== 32'd0 ||
        out_cyctype_dir !== 4'hA) begin
      errors++;
      $display("FAIL dma_write_fields got v=%b ch=%0d tc=%b s=%0d d=%h a=%h c=%h expected v=1 ch=2 tc=1 s=3 d=87654321 a=0 c=a",
               out_valid, out_dma_channel, out_dma_tc, out_size, out_data, out_addr, out_cyctype_dir);
    end
    step(1'b1, 4'hF); step(1'b1, 4'hF);
    checks++;
    if (v2cnt != w0) begin
      errors++; $display("FAIL dma_disabled_valid got %0d expected 0", v2cnt - w0);
    end
  endtask

  task automatic test_abort();
    int a0 = acnt;
    step(1'b0, 4'h0); step(1'b1, 4'h0); step(1'b1, 4'h1); step(1'b1, 4'h2);
    step(1'b0, 4'hF);
    checks++;
    if (out_abort !== 1'b1) begin
      errors++; $display("FAIL abort_pulse got %b expected 1", out_abort);
    end
    step(1'b1, 4'h0);
    checks++;
    if (out_abort !== 1'b0) begin
      errors++; $display("FAIL abort_width got %b expected 0", out_abort);
    end
    step(1'b0, 4'h0); step(1'b1, 4'h0);
    step(1'b1, 4'h4); step(1'b1, 4'h3); step(1'b1, 4'h2); step(1'b1, 4'h1);
    step(1'b1, 4'hF); step(1'b1, 4'hF);
    step(1'b1, 4'h0); step(1'b1, 4'h9); step(1'b1, 4'h6);
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 32'h0000_4321 || out_data !== 32'h0000_0069 ||
        acnt - a0 != 1) begin
      errors++;
      $display("FAIL abort_then_read got v=%b a=%h d=%h ab=%0d expected v=1 a=00004321 d=00000069 ab=1",
               out_valid, out_addr, out_data, acnt - a0);
    end
    step(1'b1, 4'hF); step(1'b1, 4'hF);
  endtask

  task automatic test_back_to_back();
    step(1'b0, 4'h0); step(1'b1, 4'h2);
    step(1'b1, 4'h0); step(1'b1, 4'h0); step(1'b1, 4'h1); step(1'b1, 4'h2);
    step(1'b1, 4'h1); step(1'b1, 4'h2);
    step(1'b1, 4'hF); step(1'b1, 4'hF);
    step(1'b1, 4'hA);
    checks++;
    if (out_valid !== 1'b1 || out_error !== 1'b1 || out_data !== 32'h0000_0021 ||
        out_addr !== 32'h0000_0012) begin
      errors++;
      $display("FAIL sync_error got v=%b e=%b d=%h a=%h expected v=1 e=1 d=00000021 a=00000012",
               out_valid, out_error, out_data, out_addr);
    end
    step(1'b1, 4'hF); step(1'b1, 4'hF);
    step(1'b0, 4'h0); step(1'b1, 4'h0);
    checks++;
    if (out_error !== 1'b0 || out_data !== 32'd0) begin
      errors++; $display("FAIL accept_clears got e=%b d=%h expected e=0 d=0", out_error, out_data);
    end
    step(1'b1, 4'h0); step(1'b1, 4'h0); step(1'b1, 4'h0); step(1'b1, 4'h7);
    step(1'b1, 4'hF); step(1'b1, 4'hF);
    step(1'b1, 4'h0); step(1'b1, 4'h5);
    step(1'b0, 4'h0);
    checks++;
    if (out_valid !== 1'b1 || out_abort !== 1'b0 || out_data !== 32'h0000_0005 ||
        out_addr !== 32'h0000_0007) begin
      errors++;
      $display("FAIL complete_with_start got v=%b ab=%b d=%h a=%h expected v=1 ab=0 d=00000005 a=00000007",
               out_valid, out_abort, out_data, out_addr);
    end
    step(1'b1, 4'h2);
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_cyctype_dir !== 4'h2) begin
      errors++;
      $display("FAIL start_after_complete got v=%b d=%h c=%h expected v=0 d=0 c=2",
               out_valid, out_data, out_cyctype_dir);
    end
    step(1'b1, 4'h0); step(1'b1, 4'h0); step(1'b1, 4'h0); step(1'b1, 4'h3);
    step(1'b1, 4'h4); step(1'b1, 4'h4);
    step(1'b1, 4'hF); step(1'b1, 4'hF);
    step(1'b1, 4'h0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000_0044 || out_addr !== 32'h0000_0003) begin
      errors++;
      $display("FAIL second_cycle got v=%b d=%h a=%h expected v=1 d=00000044 a=00000003",
               out_valid, out_data, out_addr);
    end
    step(1'b1, 4'hF); step(1'b1, 4'hF);
  endtask

  task automatic test_reset_mid();
    int a0 = acnt;
    step(1'b0, 4'h0); step(1'b1, 4'h0);
    step(1'b1, 4'h0); step(1'b1, 4'h0); step(1'b1, 4'h0); step(1'b1, 4'h9);
    step(1'b1, 4'hF); step(1'b1, 4'hF);
    step(1'b1, 4'h0); step(1'b1, 4'h3);
    reset = 1'b1;
    step(1'b1, 4'hC);
    checks++;
    if (all_out !== 78'd0) begin
      errors++; $display("FAIL reset_in_pdata got %h expected 0", all_out);
    end
    reset = 1'b0;
    step(1'b1, 4'hC);
    step(1'b0, 4'h0); step(1'b1, 4'h2);
    step(1'b1, 4'h0); step(1'b1, 4'h0); step(1'b1, 4'h0); step(1'b1, 4'h1);
    step(1'b1, 4'h6); step(1'b1, 4'h6);
    step(1'b1, 4'hF); step(1'b1, 4'hF);
    step(1'b1, 4'h0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000_0066 || out_addr !== 32'h0000_0001 ||
        acnt != a0) begin
      errors++;
      $display("FAIL after_reset_cycle got v=%b d=%h a=%h ab=%0d expected v=1 d=00000066 a=00000001 ab=0",
               out_valid, out_data, out_addr, acnt - a0);
    end
    step(1'b1, 4'hF); step(1'b1, 4'hF);
    step(1'b0, 4'h0); step(1'b1, 4'h2); step(1'b1, 4'h0); step(1'b1, 4'h0);
    lpc_reset = 1'b0;
    step(1'b1, 4'h1);
    lpc_reset = 1'b1;
    checks++;
    if (all_out !== 78'd0) begin
      errors++; $display("FAIL lreset_mid_addr got %h expected 0", all_out);
    end
    step(1'b1, 4'h1); step(1'b1, 4'h5); step(1'b1, 4'h5);
    checks++;
    if (all_out !== 78'd0) begin
      errors++; $display("FAIL lreset_stays_idle got %h expected 0", all_out);
    end
  endtask

  initial begin
    test_reset();
    test_io_write();
    test_unsupported();
    test_mem_read();
    test_wait_boundary();
    test_timeout();
    test_dma_write();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
